uart_transmitter: RTL and testbench

Serial transmit stage of the UART channel, directly downstream of the baud controller. It consumes the controller's `sample_ENABLE` tick and shifts a byte out on `TxD` as a framed asynchronous character: start bit, 8 data bits LSB-first, optional even parity, stop bit. A one-entry holding register lets the host queue the next byte while a frame is in flight, so consecutive frames go out back-to-back.

---
 rtl/uart_transmitter_if.sv | 13 +
 rtl/uart_transmitter.sv | 141 ++++++++++++++
 tb/tb_uart_transmitter.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_transmitter_if.sv
// Host-side write/status bundle of the UART transmitter: write strobe, data,
// enable, and the FULL/BUSY/DONE status flags.
interface uart_transmitter_if;
  logic       Tx_EN;
  logic       Tx_WR;
  logic [7:0] Tx_DATA;
  logic       Tx_FULL;
  logic       Tx_BUSY;
  logic       Tx_DONE;

  modport master (output Tx_EN, Tx_WR, Tx_DATA, input  Tx_FULL, Tx_BUSY, Tx_DONE);
  modport slave  (input  Tx_EN, Tx_WR, Tx_DATA, output Tx_FULL, Tx_BUSY, Tx_DONE);
endinterface

// File: rtl/uart_transmitter.sv
// UART transmit stage: start, 8 data bits LSB-first, optional even parity
// (macro UART_TX_PARITY_EN), stop. One-entry holding register for back-to-back frames.
module uart_transmitter #(
  parameter int OVERSAMPLE = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_ENABLE,
  uart_transmitter_if.slave host,
  output logic              TxD
);
  localparam int               CNT_W    = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state, state_n;
  logic [7:0]       hold, hold_n;
  logic [7:0]       shreg, shreg_n;
  logic             full, full_n;
  logic             done, done_n;
  logic             txd_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       idx, idx_n;
`ifdef UART_TX_PARITY_EN
  logic             par, par_n;
`endif

  logic tick_last, can_start, accept, load;

  assign tick_last = sample_ENABLE && (cnt == CNT_LAST);
  assign can_start = sample_ENABLE && full && host.Tx_EN;
  assign accept    = host.Tx_WR && host.Tx_EN && !full;
  // A new frame is launched either from IDLE or straight out of the stop bit.
  assign load      = can_start && ((state == IDLE) || (state == STOP && tick_last));

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latches).
    state_n = state;
    hold_n  = hold;
    shreg_n = shreg;
    full_n  = full;
    cnt_n   = cnt;
    idx_n   = idx;
    done_n  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n   = par;
`endif

    if (accept) begin
      hold_n = host.Tx_DATA;
      full_n = 1'b1;
    end

    if (sample_ENABLE && state != IDLE)
      cnt_n = tick_last ? '0 : cnt + CNT_W'(1);

    case (state)
      START: if (tick_last) begin
        state_n = DATA;
        idx_n   = 3'd0;
      end
      DATA: if (tick_last) begin
        shreg_n = shreg >> 1;
        idx_n   = idx + 3'd1;
`ifdef UART_TX_PARITY_EN
        par_n   = par ^ shreg[0];
        if (idx == 3'd7) state_n = PARITY;
`else
        if (idx == 3'd7) state_n = STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (tick_last) state_n = STOP;
`endif
      STOP: if (tick_last) begin
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: ;
    endcase

    if (load) begin
      state_n = START;
      shreg_n = hold;
      full_n  = 1'b0;
      cnt_n   = '0;
      idx_n   = 3'd0;
`ifdef UART_TX_PARITY_EN
      par_n   = 1'b0;
`endif
    end

    // Line level is derived from the next state so TxD itself can be a flop.
    case (state_n)
      START:   txd_n = 1'b0;
      DATA:    txd_n = shreg_n[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_n = par_n;
`endif
      default: txd_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      hold  <= '0;
      shreg <= '0;
      full  <= 1'b0;
      cnt   <= '0;
      idx   <= '0;
      done  <= 1'b0;
      TxD   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state <= state_n;
      hold  <= hold_n;
      shreg <= shreg_n;
      full  <= full_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      done  <= done_n;
      TxD   <= txd_n;
`ifdef UART_TX_PARITY_EN
      par   <= par_n;
`endif
    end
  end

  assign host.Tx_FULL = full;
  assign host.Tx_DONE = done;
  assign host.Tx_BUSY = (state != IDLE) || full;
endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: directed and random bytes decoded
// off TxD clock-by-clock against a frame model built from the byte value.
module tb_uart_transmitter;
  localparam int OVERSAMPLE = 16;
  localparam int TICK_DIV   = 4;
  localparam int BIT_CLKS   = OVERSAMPLE * TICK_DIV;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic clk;
  logic reset;
  logic sample_ENABLE;
  logic TxD;

  uart_transmitter_if bus ();

  uart_transmitter #(.OVERSAMPLE(OVERSAMPLE)) dut (
    .clk           (clk),
    .reset         (reset),
    .sample_ENABLE (sample_ENABLE),
    .host          (bus),
    .TxD           (TxD)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  int         done_cnt = 0;
  int         frames_seen = 0;
  int         b2b_cnt = 0;
  logic [7:0] exp_q[$];

  int         d0, f0, b0, ticks;
  bit         found, ok, low_seen, full_seen;
  logic       se;
  logic [7:0] d;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Baud tick: one clock high every TICK_DIV clocks.
  initial begin
    int tdiv;
    tdiv = 0;
    sample_ENABLE = 1'b0;
    forever begin
      @(negedge clk);
      tdiv = (tdiv == TICK_DIV - 1) ? 0 : tdiv + 1;
      sample_ENABLE = (tdiv == 0);
    end
  end

  initial begin
    #(800_000);
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected line levels, index 0 = start bit.
  function automatic logic [NBITS-1:0] frame_of(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b1, b, 1'b0};
`endif
  endfunction

  // Called at the first sample showing the start bit; returns at the sample
  // just after the frame's final edge (or as soon as reset is seen).
  task automatic mon_frame();
    logic [7:0]       b;
    logic [NBITS-1:0] fr;
    logic             got;
    check("frame_expected", exp_q.size() != 0, 1);
    b  = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
    fr = frame_of(b);
    for (int i = 0; i < NBITS; i++) begin
      got = fr[i];
      for (int k = 0; k < BIT_CLKS; k++) begin
        if (i != 0 || k != 0) begin
          @(posedge clk); #1;
        end
        if (reset !== 1'b1) return;
        if (TxD !== fr[i]) got = TxD;
      end
      check($sformatf("tx_%02h_bit%0d", b, i), got, fr[i]);
    end
    @(posedge clk); #1;
    if (reset !== 1'b1) return;
    check($sformatf("tx_%02h_done", b), bus.Tx_DONE, 1);
    frames_seen++;
    if (TxD === 1'b0) b2b_cnt++;
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      while (reset === 1'b1 && TxD === 1'b0) mon_frame();
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (bus.Tx_DONE === 1'b1) done_cnt++;
    end
  end

  task automatic wr(input logic [7:0] b, input bit expect_accept);
    @(negedge clk);
    bus.Tx_WR   = 1'b1;
    bus.Tx_DATA = b;
    @(posedge clk); #1;
    bus.Tx_WR   = 1'b0;
    if (expect_accept) exp_q.push_back(b);
  endtask

  task automatic wait_start(input string tag);
    bit hit;
    hit = 0;
    for (int i = 0; i < 400 && !hit; i++) begin
      @(posedge clk); #1;
      if (TxD === 1'b0) hit = 1;
    end
    check(tag, hit, 1);
  endtask

  task automatic wait_not_full(input string tag);
    bit hit;
    hit = 0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      if (bus.Tx_FULL === 1'b0) hit = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    check(tag, hit, 1);
  endtask

  task automatic wait_idle(input string tag, input int bound);
    bit hit;
    hit = 0;
    for (int i = 0; i < bound && !hit; i++) begin
      @(posedge clk); #1;
      if (bus.Tx_BUSY === 1'b0 && exp_q.size() == 0) hit = 1;
    end
    check(tag, hit, 1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b0;
    bus.Tx_EN   = 1'b1;
    bus.Tx_WR   = 1'b0;
    bus.Tx_DATA = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_txd",  TxD, 1);
    check("rst_full", bus.Tx_FULL, 0);
    check("rst_busy", bus.Tx_BUSY, 0);
    check("rst_done", bus.Tx_DONE, 0);
    @(negedge clk);
    reset = 1'b1;

    // Single frame, write latency and tick-aligned start.
    d0 = done_cnt; f0 = frames_seen;
    wr(8'hA5, 1);
    check("full_latency", bus.Tx_FULL, 1);
    ticks = 0; found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(posedge clk);
      se = sample_ENABLE;
      #1;
      if (se) ticks++;
      if (TxD === 1'b0) found = 1;
    end
    check("start_found", found, 1);
    check("start_on_first_tick", ticks, 1);
    wait_idle("idle_a5", 3000);
    check("a5_frames", frames_seen - f0, 1);
    check("a5_done_pulses", done_cnt - d0, 1);
    check("a5_busy_low", bus.Tx_BUSY, 0);
    check("a5_txd_idle", TxD, 1);

    wr(8'h3C, 1);
    wait_idle("idle_3c", 3000);

    // Back-to-back frames; third write while full is dropped.
    d0 = done_cnt; f0 = frames_seen; b0 = b2b_cnt;
    wr(8'h01, 1);
    wait_not_full("b2b_first_loaded");
    wr(8'h80, 1);
    wr(8'hFF, 0);
    wait_idle("idle_b2b", 4000);
    check("b2b_frames", frames_seen - f0, 2);
    check("b2b_done_pulses", done_cnt - d0, 2);
    check("b2b_no_gap", b2b_cnt - b0, 1);

    // Writes ignored while disabled.
    bus.Tx_EN = 1'b0;
    wr(8'h55, 0);
    low_seen = 0; full_seen = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (TxD !== 1'b1) low_seen = 1;
      if (bus.Tx_FULL !== 1'b0) full_seen = 1;
    end
    check("en_off_txd_low", low_seen, 0);
    check("en_off_full", full_seen, 0);

    // Disable mid-frame with a byte pending: frame completes, byte is held.
    bus.Tx_EN = 1'b1;
    wr(8'h5A, 1);
    wait_start("en_start");
    wr(8'hC3, 1);
    @(negedge clk);
    bus.Tx_EN = 1'b0;
    d0 = done_cnt;
    ok = 0;
    for (int i = 0; i < NBITS * BIT_CLKS + 200 && !ok; i++) begin
      @(posedge clk); #1;
      if (done_cnt != d0) ok = 1;
    end
    check("en_frame_done", ok, 1);
    repeat (3 * BIT_CLKS) @(posedge clk);
    #1;
    check("held_full", bus.Tx_FULL, 1);
    check("held_txd",  TxD, 1);
    check("held_busy", bus.Tx_BUSY, 1);
    check("held_pending", exp_q.size(), 1);
    @(negedge clk);
    bus.Tx_EN = 1'b1;
    wait_idle("idle_en", 3000);

    // Random bytes with random spacing and occasional dropped writes.
    f0 = frames_seen;
    for (int n = 0; n < 8; n++) begin
      wait_not_full("rand_not_full");
      repeat ($urandom_range(0, 150)) @(negedge clk);
      d = 8'($urandom);
      wr(d, 1);
      if ($urandom_range(0, 2) == 0) wr(~d, 0);
    end
    wait_idle("idle_rand", 5000);
    check("rand_frames", frames_seen - f0, 8);

    // Asynchronous reset during data bit 3 with a byte pending.
    wr(8'h96, 1);
    wait_start("rst_start");
    wr(8'h69, 1);
    repeat (4 * BIT_CLKS + 20) @(posedge clk);
    @(negedge clk);
    check("pre_rst_txd", TxD, 0);
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid_txd",  TxD, 1);
    check("rst_mid_full", bus.Tx_FULL, 0);
    check("rst_mid_busy", bus.Tx_BUSY, 0);
    repeat (3) @(negedge clk);
    exp_q.delete();
    reset = 1'b1;
    low_seen = 0;
    repeat (200) begin
      @(posedge clk); #1;
      if (TxD !== 1'b1) low_seen = 1;
    end
    check("rst_byte_lost", low_seen, 0);
    check("done_vs_frames", done_cnt, frames_seen);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
